// File: rtl/mem_stage.sv
// MEM pipeline stage: performs loads/stores over a req/ack data-memory bus and drives MEM/WB fields.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses are dropped with a one-cycle misalign_o strobe.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic [1:0]  M_i,
    input  logic [31:0] ALU_output_i,
    input  logic [31:0] fw2_i,
    input  logic [4:0]  reg_dst_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [1:0]  WB_o,
    output logic [31:0] mem_data_o,
    output logic [31:0] ALU_output_o,
    output logic [4:0]  reg_dst_o,
    output logic        bus_err_o,
    output logic        misalign_o
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       hold_wb, hold_wb_nxt;
    logic [4:0]       hold_rd, hold_rd_nxt;
    logic             req_nxt, we_nxt, bus_err_nxt, misalign_nxt;
    logic [31:0]      addr_nxt, wdata_nxt, mem_data_nxt, alu_nxt;
    logic [1:0]       wb_nxt;
    logic [4:0]       rd_nxt;
    logic             access, misaligned;

    assign access = |M_i;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access && (ALU_output_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // State and all output/holding registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            hold_wb      <= '0;
            hold_rd      <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            WB_o         <= '0;
            mem_data_o   <= '0;
            ALU_output_o <= '0;
            reg_dst_o    <= '0;
            bus_err_o    <= 1'b0;
            misalign_o   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hold_wb      <= hold_wb_nxt;
            hold_rd      <= hold_rd_nxt;
            dmem_req_o   <= req_nxt;
            dmem_we_o    <= we_nxt;
            dmem_addr_o  <= addr_nxt;
            dmem_wdata_o <= wdata_nxt;
            WB_o         <= wb_nxt;
            mem_data_o   <= mem_data_nxt;
            ALU_output_o <= alu_nxt;
            reg_dst_o    <= rd_nxt;
            bus_err_o    <= bus_err_nxt;
            misalign_o   <= misalign_nxt;
        end
    end

    // Next-state and stall; bus address/data registers double as the in-flight holding copy
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        hold_wb_nxt  = hold_wb;
        hold_rd_nxt  = hold_rd;
        req_nxt      = dmem_req_o;
        we_nxt       = dmem_we_o;
        addr_nxt     = dmem_addr_o;
        wdata_nxt    = dmem_wdata_o;
        wb_nxt       = WB_o;
        mem_data_nxt = mem_data_o;
        alu_nxt      = ALU_output_o;
        rd_nxt       = reg_dst_o;
        bus_err_nxt  = bus_err_o;
        misalign_nxt = 1'b0;
        stall_o      = 1'b0;

        case (state)
            IDLE: begin
                if (misaligned) begin
                    wb_nxt       = 2'b00;
                    alu_nxt      = ALU_output_i;
                    rd_nxt       = reg_dst_i;
                    misalign_nxt = 1'b1;
                end else if (access) begin
                    stall_o     = 1'b1;
                    addr_nxt    = ALU_output_i;
                    wdata_nxt   = fw2_i;
                    we_nxt      = M_i[0];
                    hold_wb_nxt = WB_i;
                    hold_rd_nxt = reg_dst_i;
                    req_nxt     = 1'b1;
                    cnt_nxt     = '0;
                    wb_nxt      = 2'b00;
                    state_nxt   = BUSY;
                end else begin
                    wb_nxt  = WB_i;
                    alu_nxt = ALU_output_i;
                    rd_nxt  = reg_dst_i;
                end
            end
            BUSY: begin
                if (dmem_ack_i) begin
                    wb_nxt    = hold_wb;
                    alu_nxt   = dmem_addr_o;
                    rd_nxt    = hold_rd;
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                    if (!dmem_we_o) begin
                        mem_data_nxt = dmem_rdata_i;
                    end
                end else if (cnt == CNT_LAST) begin
                    // Abort: release the pipeline, suppress write-back, flag the error
                    bus_err_nxt = 1'b1;
                    wb_nxt      = 2'b00;
                    req_nxt     = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    stall_o = 1'b1;
                    wb_nxt  = 2'b00;
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (default TIMEOUT_CYC=16).
module tb_mem_stage;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i;
    logic [1:0]  M_i;
    logic [31:0] ALU_output_i;
    logic [31:0] fw2_i;
    logic [4:0]  reg_dst_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic [1:0]  WB_o;
    logic [31:0] mem_data_o;
    logic [31:0] ALU_output_o;
    logic [4:0]  reg_dst_o;
    logic        bus_err_o;
    logic        misalign_o;

    int n_chk  = 0;
    int n_pass = 0;

    mem_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .WB_i         (WB_i),
        .M_i          (M_i),
        .ALU_output_i (ALU_output_i),
        .fw2_i        (fw2_i),
        .reg_dst_i    (reg_dst_i),
        .stall_o      (stall_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ack_i   (dmem_ack_i),
        .WB_o         (WB_o),
        .mem_data_o   (mem_data_o),
        .ALU_output_o (ALU_output_o),
        .reg_dst_o    (reg_dst_o),
        .bus_err_o    (bus_err_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] alu,
                         input logic [31:0] fw2, input logic [4:0] rd);
        WB_i         = wb;
        M_i          = m;
        ALU_output_i = alu;
        fw2_i        = fw2;
        reg_dst_i    = rd;
    endtask

    initial begin
        int stalls;
        rst_i        = 1'b1;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        chk("rst_wb", 32'(WB_o), 32'h0);
        chk("rst_req", 32'(dmem_req_o), 32'h0);
        chk("rst_bus_err", 32'(bus_err_o), 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        chk("rst_misalign", 32'(misalign_o), 32'h0);
        rst_i = 1'b0;

        // ALU op passes straight through in one cycle
        drive(2'b10, 2'b00, 32'h2A, 32'h0, 5'd5);
        #1 chk("alu_stall", 32'(stall_o), 32'h0);
        tick();
        chk("alu_wb", 32'(WB_o), 32'h2);
        chk("alu_res", ALU_output_o, 32'h2A);
        chk("alu_rd", 32'(reg_dst_o), 32'd5);

        // Load, ack in 4th BUSY cycle: four stall cycles
        drive(2'b11, 2'b10, 32'h100, 32'h0, 5'd7);
        #1 chk("ld_stall0", 32'(stall_o), 32'h1);
        tick();
        chk("ld_req", 32'(dmem_req_o), 32'h1);
        chk("ld_we", 32'(dmem_we_o), 32'h0);
        chk("ld_addr", dmem_addr_o, 32'h100);
        chk("ld_wb_bubble", 32'(WB_o), 32'h0);
        chk("ld_stall1", 32'(stall_o), 32'h1);
        tick();
        chk("ld_stall2", 32'(stall_o), 32'h1);
        tick();
        chk("ld_stall3", 32'(stall_o), 32'h1);
        chk("ld_wb_bubble3", 32'(WB_o), 32'h0);
        tick();
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hDEADBEEF;
        #1 chk("ld_ack_stall", 32'(stall_o), 32'h0);
        tick();
        dmem_ack_i = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("ld_wb", 32'(WB_o), 32'h3);
        chk("ld_data", mem_data_o, 32'hDEADBEEF);
        chk("ld_rd", 32'(reg_dst_o), 32'd7);
        chk("ld_alu", ALU_output_o, 32'h100);
        chk("ld_req_drop", 32'(dmem_req_o), 32'h0);

        // Store, ack in 1st BUSY cycle: one stall cycle, load data untouched
        drive(2'b00, 2'b01, 32'h40, 32'h12345678, 5'd0);
        #1 chk("st_stall0", 32'(stall_o), 32'h1);
        tick();
        chk("st_req", 32'(dmem_req_o), 32'h1);
        chk("st_we", 32'(dmem_we_o), 32'h1);
        chk("st_wdata", dmem_wdata_o, 32'h12345678);
        chk("st_addr", dmem_addr_o, 32'h40);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h55555555;
        #1 chk("st_ack_stall", 32'(stall_o), 32'h0);
        tick();
        dmem_ack_i = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("st_req_drop", 32'(dmem_req_o), 32'h0);
        chk("st_mem_data_kept", mem_data_o, 32'hDEADBEEF);
        chk("st_alu", ALU_output_o, 32'h40);
        chk("st_wb", 32'(WB_o), 32'h0);

        // Load with no ack: 16 stall cycles, released on the 17th, sticky error
        dmem_rdata_i = 32'hA5A5A5A5;
        drive(2'b11, 2'b10, 32'h200, 32'h0, 5'd9);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall_o) break;
            stalls++;
            tick();
        end
        chk("to_stall_cycles", 32'(stalls), 32'd16);
        chk("to_req_last", 32'(dmem_req_o), 32'h1);
        chk("to_wb_bubble", 32'(WB_o), 32'h0);
        chk("to_err_pre", 32'(bus_err_o), 32'h0);
        tick();
        drive(2'b10, 2'b00, 32'h55, 32'h0, 5'd3);
        chk("to_err", 32'(bus_err_o), 32'h1);
        chk("to_req_drop", 32'(dmem_req_o), 32'h0);
        chk("to_wb_suppr", 32'(WB_o), 32'h0);
        chk("to_mem_data_kept", mem_data_o, 32'hDEADBEEF);

        // Ack while IDLE is ignored; normal ops resume, error stays
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hCAFEF00D;
        tick();
        dmem_ack_i = 1'b0;
        chk("idle_ack_data", mem_data_o, 32'hDEADBEEF);
        chk("idle_ack_req", 32'(dmem_req_o), 32'h0);
        chk("resume_wb", 32'(WB_o), 32'h2);
        chk("resume_alu", ALU_output_o, 32'h55);
        chk("err_sticky", 32'(bus_err_o), 32'h1);

        // Async reset in the middle of a BUSY wait
        drive(2'b11, 2'b10, 32'h300, 32'h0, 5'd2);
        tick();
        chk("mr_req_busy", 32'(dmem_req_o), 32'h1);
        #2 rst_i = 1'b1;
        #1;
        chk("mr_req", 32'(dmem_req_o), 32'h0);
        chk("mr_wb", 32'(WB_o), 32'h0);
        chk("mr_bus_err", 32'(bus_err_o), 32'h0);
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        #1 chk("mr_idle_stall", 32'(stall_o), 32'h0);
        rst_i = 1'b0;
        tick();

        // Misaligned load
        drive(2'b11, 2'b10, 32'h102, 32'h0, 5'd4);
`ifdef MEM_ALIGN_CHECK_EN
        #1 chk("ma_stall", 32'(stall_o), 32'h0);
        tick();
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("ma_req", 32'(dmem_req_o), 32'h0);
        chk("ma_strobe", 32'(misalign_o), 32'h1);
        chk("ma_wb", 32'(WB_o), 32'h0);
        chk("ma_alu", ALU_output_o, 32'h102);
        chk("ma_rd", 32'(reg_dst_o), 32'd4);
        tick();
        chk("ma_strobe_off", 32'(misalign_o), 32'h0);
`else
        #1 chk("ma_stall", 32'(stall_o), 32'h1);
        tick();
        chk("ma_req", 32'(dmem_req_o), 32'h1);
        chk("ma_addr", dmem_addr_o, 32'h102);
        chk("ma_strobe", 32'(misalign_o), 32'h0);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h0BADF00D;
        tick();
        dmem_ack_i = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("ma_data", mem_data_o, 32'h0BADF00D);
        chk("ma_wb", 32'(WB_o), 32'h3);
        chk("ma_rd", 32'(reg_dst_o), 32'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
